// File: rtl/cfg_bus_pkg.sv
// rtl/cfg_bus_pkg.sv - shared constants, request struct, FSM states and pin packing for cfg_bus_writer
package cfg_bus_pkg;

    localparam int CFG_ADDR_BITS     = 3;
    localparam int CFG_WORDS         = 8;
    localparam int CFG_SKIP_MIN_ADDR = 5;

    // Bit positions inside pin_ui.
    localparam int PIN_STROBE   = 7;
    localparam int PIN_ADDR_LSB = 1;
    localparam int PIN_BYTE_SEL = 0;

    typedef struct packed {
        logic [CFG_ADDR_BITS-1:0] addr;
        logic [15:0]              data;
        logic [1:0]               be;
    } cfg_req_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_HIGH,
        ST_LOW
    } cfg_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Unused bits 6:4 stay 0.
    function automatic logic [7:0] make_pin_ui(input logic strobe,
                                               input logic [CFG_ADDR_BITS-1:0] addr,
                                               input logic sel);
        logic [7:0] v;
        v = 8'h00;
        v[PIN_STROBE] = strobe;
        v[PIN_ADDR_LSB +: CFG_ADDR_BITS] = addr;
        v[PIN_BYTE_SEL] = sel;
        return v;
    endfunction

endpackage

// File: rtl/cfg_bus_writer_if.sv
// rtl/cfg_bus_writer_if.sv - request handshake bundle: req_valid/req_ready with addr, data, byte enables
import cfg_bus_pkg::*;

interface cfg_bus_writer_if;
    logic                     req_valid;
    logic                     req_ready;
    logic [CFG_ADDR_BITS-1:0] req_addr;
    logic [15:0]              req_data;
    logic [1:0]               req_be;

    modport master (
        output req_valid, req_addr, req_data, req_be,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_be,
        output req_ready
    );
endinterface

// File: rtl/cfg_req_fifo.sv
// rtl/cfg_req_fifo.sv - synchronous FIFO of cfg_req_t with full/empty and simultaneous push/pop
// Ports: clk, reset (sync, active-high, flushes), push/push_data, pop/pop_data (head, combinational),
//        full, empty. Push is ignored when full, pop is ignored when empty.
import cfg_bus_pkg::*;

module cfg_req_fifo #(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  cfg_req_t push_data,
    input  logic     pop,
    output cfg_req_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cfg_req_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push_ok;
    logic            pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cfg_bus_writer.sv
// rtl/cfg_bus_writer.sv - serialises buffered 16-bit config writes onto a strobed byte-wide pin bundle
// Ports: clk, reset (sync, active-high); req (cfg_bus_writer_if.slave: req_valid/req_ready/req_addr/
//        req_data/req_be); busy; pin_ui {strobe,000,addr[2:0],byte_sel}; pin_uio byte data;
//        skipped (pulse when a byte is suppressed).
// Optional feature: CFG_BUS_WRITER_SKIP_SAME_EN keeps a shadow of the receiver and skips redundant
//        bytes on words CFG_SKIP_MIN_ADDR..7.
import cfg_bus_pkg::*;

module cfg_bus_writer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int SETUP_CYCLES = 2,
    parameter int HIGH_CYCLES  = 8,
    parameter int LOW_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              reset,
    cfg_bus_writer_if.slave   req,
    output logic              busy,
    output logic [7:0]        pin_ui,
    output logic [7:0]        pin_uio,
    output logic              skipped
);

    localparam int CNT_MAX = max3(SETUP_CYCLES, HIGH_CYCLES, LOW_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    cfg_state_t               state;
    logic [CNT_W-1:0]         cnt;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic                     fifo_pop;
    cfg_req_t                 fifo_head;
    cfg_req_t                 fifo_in;

    logic [CFG_ADDR_BITS-1:0] w_addr;
    logic [15:0]              w_data;
    logic [1:0]               w_pend;

    logic                     has_pend;
    logic                     sel_hi;
    logic [7:0]               cur_byte;
    logic                     load_skip;

    assign req.req_ready = !reset && !fifo_full;
    assign fifo_push     = req.req_valid && req.req_ready;
    assign fifo_pop      = (state == ST_IDLE) && !fifo_empty;
    assign busy          = !reset && ((state != ST_IDLE) || !fifo_empty);

    always_comb begin
        fifo_in      = '0;
        fifo_in.addr = req.req_addr;
        fifo_in.data = req.req_data;
        fifo_in.be   = req.req_be;
    end

    cfg_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Low byte goes first: once bit0 is cleared the high byte is next.
    assign has_pend = |w_pend;
    assign sel_hi   = !w_pend[0];
    assign cur_byte = sel_hi ? w_data[15:8] : w_data[7:0];

`ifdef CFG_BUS_WRITER_SKIP_SAME_EN
    // Mirror of the receiver's 16 config bytes; index is {word, byte_sel}.
    logic [7:0] shadow [2*CFG_WORDS];
    logic [3:0] shadow_idx;

    assign shadow_idx = {w_addr, sel_hi};
    // Words below CFG_SKIP_MIN_ADDR are rewritten by the receiver's sweeps, so the
    // shadow cannot be trusted there.
    assign load_skip  = (state == ST_LOAD) && has_pend &&
                        (32'(w_addr) >= CFG_SKIP_MIN_ADDR) &&
                        (shadow[shadow_idx] == cur_byte);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2*CFG_WORDS; i++) begin
                shadow[i] <= 8'hFF;
            end
        end else if ((state == ST_LOAD) && has_pend && !load_skip) begin
            shadow[shadow_idx] <= cur_byte;
        end
    end
`else
    assign load_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            w_addr  <= '0;
            w_data  <= '0;
            w_pend  <= '0;
            pin_ui  <= 8'h00;
            pin_uio <= 8'h00;
            skipped <= 1'b0;
        end else begin
            skipped <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        w_addr <= fifo_head.addr;
                        w_data <= fifo_head.data;
                        w_pend <= fifo_head.be;
                        state  <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (load_skip) begin
                        // Drop this byte and re-evaluate LOAD for the next one.
                        w_pend[sel_hi] <= 1'b0;
                        skipped        <= 1'b1;
                    end else if (has_pend) begin
                        pin_ui         <= make_pin_ui(1'b0, w_addr, sel_hi);
                        pin_uio        <= cur_byte;
                        w_pend[sel_hi] <= 1'b0;
                        cnt            <= CNT_W'(SETUP_CYCLES - 1);
                        state          <= ST_SETUP;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_SETUP: begin
                    if (cnt == '0) begin
                        pin_ui[PIN_STROBE] <= 1'b1;
                        cnt                <= CNT_W'(HIGH_CYCLES - 1);
                        state              <= ST_HIGH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_HIGH: begin
                    if (cnt == '0) begin
                        pin_ui[PIN_STROBE] <= 1'b0;
                        cnt                <= CNT_W'(LOW_CYCLES - 1);
                        state              <= ST_LOW;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_LOW: begin
                    if (cnt == '0) begin
                        state <= ST_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    pin_ui[PIN_STROBE] <= 1'b0;
                    state              <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
